// File: rtl/im_arbiter.sv
// Two-port arbiter sharing one instruction memory between processor fetch and a host loader.
// Fetch has priority, and the host is guaranteed a slot after STARVE_MAX consecutive contested losses.
module im_arbiter #(
  parameter int NMEM       = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_valid,
  output logic [31:0] host_rdata,
  output logic        host_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_HOST  = 2'd2
  } owner_t;

  owner_t        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          respOor_q, respOor_d;
  logic          respWe_q, respWe_d;
  logic [31:0]   fetchData_q, fetchData_d;
  logic [31:0]   hostRdata_q, hostRdata_d;

  logic          anyGnt;
  logic [31:2]   selAddr;
  logic          selOor;
  logic          unusedAddrBits;

  // Byte-offset bits never reach the word-addressed memory.
  assign unusedAddrBits = ^{fetch_addr[1:0], host_addr[1:0]};

  function automatic logic outOfRange(input logic [31:2] addr);
    return (addr[31:9] != '0) || (int'({25'd0, addr[8:2]}) >= NMEM);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      respOor_q   <= 1'b0;
      respWe_q    <= 1'b0;
      fetchData_q <= '0;
      hostRdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      respOor_q   <= respOor_d;
      respWe_q    <= respWe_d;
      fetchData_q <= fetchData_d;
      hostRdata_q <= hostRdata_d;
    end
  end

  always_comb begin
    host_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    if (!reset) begin
      if (host_req && (!fetch_req || starve_q == STARVE_LIM)) begin
        host_gnt = 1'b1;
      end else if (fetch_req) begin
        fetch_gnt = 1'b1;
      end
    end

    anyGnt    = fetch_gnt | host_gnt;
    selAddr   = host_gnt ? host_addr[31:2] : fetch_addr[31:2];
    selOor    = outOfRange(selAddr);
    mem_en    = anyGnt & ~selOor;
    mem_we    = host_we & host_gnt;
    mem_addr  = anyGnt ? selAddr[8:2] : 7'd0;
    mem_wdata = host_wdata;

    // A fetch win only counts as starvation when the host was actually waiting.
    starve_d = starve_q;
    if (host_gnt || !host_req) begin
      starve_d = '0;
    end else if (fetch_gnt && starve_q != STARVE_LIM) begin
      starve_d = starve_q + 1'b1;
    end

    owner_d   = host_gnt ? OWN_HOST : (fetch_gnt ? OWN_FETCH : OWN_NONE);
    respOor_d = anyGnt & selOor;
    respWe_d  = host_gnt & host_we;
  end

  always_comb begin
    fetch_valid = (owner_q == OWN_FETCH) && !reset;
    host_valid  = (owner_q == OWN_HOST) && !reset;
    host_err    = host_valid & respOor_q;

    fetch_data  = fetchData_q;
    fetchData_d = fetchData_q;
    if (fetch_valid) begin
      fetch_data  = respOor_q ? 32'h0 : mem_rdata;
      fetchData_d = fetch_data;
    end

    // Write acknowledges and rejected reads both return zero data.
    host_rdata  = hostRdata_q;
    hostRdata_d = hostRdata_q;
    if (host_valid) begin
      host_rdata  = (respOor_q || respWe_q) ? 32'h0 : mem_rdata;
      hostRdata_d = host_rdata;
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
// Directed bench for im_arbiter with a behavioural one-cycle-latency memory.
module tb_im_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_gnt, fetch_valid;
  logic [31:0] fetch_addr, fetch_data;
  logic        host_req, host_we, host_gnt, host_valid, host_err;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] memArray [128];
  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  im_arbiter #(.NMEM(128), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_valid(host_valid), .host_rdata(host_rdata), .host_err(host_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Word i holds 0x2000_0000 + (i << 16) + i, so index 3 reads 0x20030003.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) memArray[i] <= 32'h2000_0000 | (i << 16) | i;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) memArray[mem_addr] <= mem_wdata;
      mem_rdata <= memArray[mem_addr];
    end
  end

  task automatic drive(input logic fr, input logic [31:0] fa, input logic hr,
                       input logic hw, input logic [31:0] ha, input logic [31:0] hd);
    fetch_req = fr; fetch_addr = fa;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h0C, 1'b1, 1'b1, 32'h20, 32'h1234);
    @(posedge clk); @(posedge clk); #1;
    nCompared++; if (fetch_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_fetch_gnt: got %0h want 0", fetch_gnt); end
    nCompared++; if (host_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_host_gnt: got %0h want 0", host_gnt); end
    nCompared++; if (mem_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mem_en: got %0h want 0", mem_en); end
    nCompared++; if (mem_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mem_we: got %0h want 0", mem_we); end
    nCompared++; if ({fetch_valid, host_valid, host_err} !== 3'b000) begin nMismatched++; $display("[TB] FAIL rst_valids: got %b want 000", {fetch_valid, host_valid, host_err}); end
    nCompared++; if ({fetch_data, host_rdata} !== 64'h0) begin nMismatched++; $display("[TB] FAIL rst_data: got %h want 0", {fetch_data, host_rdata}); end
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({fetch_gnt, host_gnt, mem_en, mem_we} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL idle_ctrl: got %b want 0000", {fetch_gnt, host_gnt, mem_en, mem_we}); end
    step();
  endtask

  task automatic test_fetch_basic();
    drive(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_fetch_gnt: got %0h want 1", fetch_gnt); end
    nCompared++; if (host_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_host_gnt: got %0h want 0", host_gnt); end
    nCompared++; if (mem_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_mem_en: got %0h want 1", mem_en); end
    nCompared++; if (mem_addr !== 7'd3) begin nMismatched++; $display("[TB] FAIL basic_mem_addr: got %0d want 3", mem_addr); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_fetch_valid: got %0h want 1", fetch_valid); end
    nCompared++; if (fetch_data !== 32'h2003_0003) begin nMismatched++; $display("[TB] FAIL basic_fetch_data: got %h want 20030003", fetch_data); end
    nCompared++; if (host_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_host_valid: got %0h want 0", host_valid); end
    step();
    nCompared++; if (fetch_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL hold_fetch_valid: got %0h want 0", fetch_valid); end
    nCompared++; if (fetch_data !== 32'h2003_0003) begin nMismatched++; $display("[TB] FAIL hold_fetch_data: got %h want 20030003", fetch_data); end
  endtask

  task automatic test_write_then_fetch();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    nCompared++; if (host_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL wr_host_gnt: got %0h want 1", host_gnt); end
    nCompared++; if ({mem_en, mem_we} !== 2'b11) begin nMismatched++; $display("[TB] FAIL wr_mem_en_we: got %b want 11", {mem_en, mem_we}); end
    nCompared++; if (mem_addr !== 7'd8) begin nMismatched++; $display("[TB] FAIL wr_mem_addr: got %0d want 8", mem_addr); end
    nCompared++; if (mem_wdata !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL wr_mem_wdata: got %h want deadbeef", mem_wdata); end
    step();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({host_valid, host_err} !== 2'b10) begin nMismatched++; $display("[TB] FAIL wr_ack: got %b want 10", {host_valid, host_err}); end
    nCompared++; if (host_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL wr_ack_rdata: got %h want 0", host_rdata); end
    nCompared++; if ({fetch_gnt, mem_we} !== 2'b10) begin nMismatched++; $display("[TB] FAIL wr_fetch_gnt_we: got %b want 10", {fetch_gnt, mem_we}); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL raw_fetch_valid: got %0h want 1", fetch_valid); end
    nCompared++; if (fetch_data !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL raw_fetch_data: got %h want deadbeef", fetch_data); end
    step();
  endtask

  task automatic test_starvation();
    logic [9:0] expHost;
    expHost = 10'b10_0001_0000;
    drive(1'b1, 32'h04, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 10; k++) begin
      nCompared++; if (host_gnt !== expHost[k]) begin nMismatched++; $display("[TB] FAIL starve_host_gnt[%0d]: got %0h want %0h", k, host_gnt, expHost[k]); end
      nCompared++; if (fetch_gnt !== ~expHost[k]) begin nMismatched++; $display("[TB] FAIL starve_fetch_gnt[%0d]: got %0h want %0h", k, fetch_gnt, ~expHost[k]); end
      if (k > 0) begin
        nCompared++; if ({host_valid, fetch_valid} !== {expHost[k-1], ~expHost[k-1]}) begin nMismatched++; $display("[TB] FAIL starve_valids[%0d]: got %b want %b", k, {host_valid, fetch_valid}, {expHost[k-1], ~expHost[k-1]}); end
        if (expHost[k-1]) begin
          nCompared++; if (host_rdata !== 32'h2004_0004) begin nMismatched++; $display("[TB] FAIL starve_host_rdata[%0d]: got %h want 20040004", k, host_rdata); end
        end else begin
          nCompared++; if (fetch_data !== 32'h2001_0001) begin nMismatched++; $display("[TB] FAIL starve_fetch_data[%0d]: got %h want 20010001", k, fetch_data); end
        end
      end
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({host_valid, fetch_valid} !== 2'b10) begin nMismatched++; $display("[TB] FAIL starve_last_valids: got %b want 10", {host_valid, fetch_valid}); end
    nCompared++; if (host_rdata !== 32'h2004_0004) begin nMismatched++; $display("[TB] FAIL starve_last_rdata: got %h want 20040004", host_rdata); end
    step();
  endtask

  task automatic test_host_oor();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
    nCompared++; if (host_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL oor_host_gnt: got %0h want 1", host_gnt); end
    nCompared++; if (mem_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL oor_host_mem_en: got %0h want 0", mem_en); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({host_valid, host_err} !== 2'b11) begin nMismatched++; $display("[TB] FAIL oor_host_resp: got %b want 11", {host_valid, host_err}); end
    nCompared++; if (host_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL oor_host_rdata: got %h want 0", host_rdata); end
    step();
    nCompared++; if (host_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL oor_err_pulse: got %0h want 0", host_err); end
  endtask

  task automatic test_fetch_oor();
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({fetch_gnt, mem_en} !== 2'b10) begin nMismatched++; $display("[TB] FAIL oor_fetch_gnt_en: got %b want 10", {fetch_gnt, mem_en}); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL oor_fetch_valid: got %0h want 1", fetch_valid); end
    nCompared++; if (fetch_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL oor_fetch_data: got %h want 0", fetch_data); end
    nCompared++; if (host_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL oor_fetch_no_err: got %0h want 0", host_err); end
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_gnt1: got %0h want 1", fetch_gnt); end
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    nCompared++; if (host_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_gnt2: got %0h want 1", host_gnt); end
    nCompared++; if ({fetch_valid, host_valid} !== 2'b10) begin nMismatched++; $display("[TB] FAIL b2b_valids2: got %b want 10", {fetch_valid, host_valid}); end
    nCompared++; if (fetch_data !== 32'h2002_0002) begin nMismatched++; $display("[TB] FAIL b2b_fetch_data2: got %h want 20020002", fetch_data); end
    step();
    drive(1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_gnt3: got %0h want 1", fetch_gnt); end
    nCompared++; if ({fetch_valid, host_valid, host_err} !== 3'b010) begin nMismatched++; $display("[TB] FAIL b2b_valids3: got %b want 010", {fetch_valid, host_valid, host_err}); end
    nCompared++; if (host_rdata !== 32'h2005_0005) begin nMismatched++; $display("[TB] FAIL b2b_host_rdata3: got %h want 20050005", host_rdata); end
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({fetch_valid, host_valid} !== 2'b10) begin nMismatched++; $display("[TB] FAIL b2b_valids4: got %b want 10", {fetch_valid, host_valid}); end
    nCompared++; if (fetch_data !== 32'h2006_0006) begin nMismatched++; $display("[TB] FAIL b2b_fetch_data4: got %h want 20060006", fetch_data); end
    nCompared++; if (host_rdata !== 32'h2005_0005) begin nMismatched++; $display("[TB] FAIL b2b_host_hold4: got %h want 20050005", host_rdata); end
    step();
  endtask

  task automatic test_reset_inflight();
    drive(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if (fetch_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL rif_gnt: got %0h want 1", fetch_gnt); end
    step();
    reset = 1'b1;
    drive(1'b1, 32'h0C, 1'b1, 1'b1, 32'h0C, 32'h0);
    nCompared++; if ({fetch_valid, host_valid} !== 2'b00) begin nMismatched++; $display("[TB] FAIL rif_valid_in_reset: got %b want 00", {fetch_valid, host_valid}); end
    nCompared++; if ({fetch_gnt, host_gnt, mem_en, mem_we} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rif_ctrl_in_reset: got %b want 0000", {fetch_gnt, host_gnt, mem_en, mem_we}); end
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++; if ({fetch_valid, host_valid, host_err} !== 3'b000) begin nMismatched++; $display("[TB] FAIL rif_valids_after: got %b want 000", {fetch_valid, host_valid, host_err}); end
    nCompared++; if (fetch_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL rif_fetch_data: got %h want 0", fetch_data); end
    nCompared++; if (host_rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL rif_host_rdata: got %h want 0", host_rdata); end
    step();
    nCompared++; if (fetch_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rif_late_valid: got %0h want 0", fetch_valid); end
  endtask

  initial begin
    reset = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_fetch_basic();
    test_write_then_fetch();
    test_starvation();
    test_host_oor();
    test_fetch_oor();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
